// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD accumulator.
package bcd_pkg;

    localparam int         BCD_DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX     = 4'd9;

    // Widest operand that is_bcd_word can inspect; callers zero-extend into it.
    localparam int MAX_DIGITS = 32;
    localparam int MAX_WORD_W = MAX_DIGITS * BCD_DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when every one of the low ndigits nibbles of word is a legal BCD digit.
    function automatic logic is_bcd_word(input logic [MAX_WORD_W-1:0] word, input int ndigits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if ((i < ndigits) && (word[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder with decimal correction; purely combinational.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] s,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] bin_sum;

    // A binary sum above 9 (which includes any binary carry) needs +6 to wrap back into BCD.
    always_comb begin
        bin_sum = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, cin};
        cout    = (bin_sum > {1'b0, BCD_MAX});
        s       = cout ? (bin_sum[BCD_DIGIT_W-1:0] + 4'd6) : bin_sum[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_accumulator.sv
// Digit-serial BCD accumulator: adds each accepted operand into a running sum, LSD first.
module bcd_serial_accumulator
    import bcd_pkg::*;
#(
    parameter  int NUM_DIGITS = 5,
    localparam int CNT_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_data,
    input  logic                    in_clear,
    output logic [4*NUM_DIGITS-1:0] acc_out,
    output logic                    acc_valid,
    output logic                    overflow,
    output logic                    in_error,
    output logic                    busy
);

    localparam int               W        = NUM_DIGITS * BCD_DIGIT_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

    state_t                   state_q, state_d;
    logic [W-1:0]             opnd_q, opnd_d;
    logic [W-1:0]             work_q, work_d;
    logic [W-1:0]             acc_q, acc_d;
    logic                     carry_q, carry_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic                     overflow_q, overflow_d;
    logic                     in_error_q, in_error_d;

    logic                     accept;
    logic                     operand_ok;
    logic [BCD_DIGIT_W-1:0]   sum_digit;
    logic                     sum_cout;
    logic [W-1:0]             work_shifted;

    assign in_ready   = (state_q != ADD);
    assign busy       = (state_q == ADD);
    assign acc_valid  = (state_q == DONE);
    assign acc_out    = acc_q;
    assign overflow   = overflow_q;
    assign in_error   = in_error_q;

    assign accept     = in_valid & in_ready;
    assign operand_ok = is_bcd_word(MAX_WORD_W'(in_data), NUM_DIGITS);

    // The working register's LSD and the operand's LSD always line up at the adder.
    bcd_digit_adder u_digit_adder (
        .a    (work_q[BCD_DIGIT_W-1:0]),
        .b    (opnd_q[BCD_DIGIT_W-1:0]),
        .cin  (carry_q),
        .s    (sum_digit),
        .cout (sum_cout)
    );

    // New digit enters at the MSD end, so after NUM_DIGITS shifts the sum is realigned.
    assign work_shifted = {sum_digit, work_q[W-1:BCD_DIGIT_W]};

    // Next-state, shift-register and result-register logic for the controller.
    always_comb begin
        state_d    = state_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;
        in_error_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (operand_ok) begin
                        opnd_d  = in_data;
                        work_d  = in_clear ? '0 : acc_q;
                        carry_d = 1'b0;
                        idx_d   = '0;
                        state_d = ADD;
                    end else begin
                        in_error_d = 1'b1;
                    end
                end
            end
            ADD: begin
                work_d  = work_shifted;
                opnd_d  = {opnd_q[BCD_DIGIT_W-1:0], opnd_q[W-1:BCD_DIGIT_W]};
                carry_d = sum_cout;
                idx_d   = idx_q + CNT_W'(1);
                if (idx_q == LAST_IDX) begin
                    acc_d      = work_shifted;
                    overflow_d = sum_cout;
                    state_d    = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state registers, with synchronous reset aborting any add in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            opnd_q     <= '0;
            work_q     <= '0;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            in_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            in_error_q <= in_error_d;
        end
    end

endmodule

// File: tb/tb_bcd_serial_accumulator.sv
// Scoreboard bench for bcd_serial_accumulator: the driver pushes expected results, a monitor checks them.
module tb_bcd_serial_accumulator;

    localparam int ND = 5;
    localparam int W  = 4 * ND;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_clear = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_ready;
    logic [W-1:0] acc_out;
    logic         acc_valid;
    logic         overflow;
    logic         in_error;
    logic         busy;

    typedef struct {
        logic         is_err;
        logic [W-1:0] acc;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [W-1:0] model_acc = '0;
    logic         model_ovf = 1'b0;

    bcd_serial_accumulator #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_clear  (in_clear),
        .acc_out   (acc_out),
        .acc_valid (acc_valid),
        .overflow  (overflow),
        .in_error  (in_error),
        .busy      (busy)
    );

    // Free-running clock and a cycle counter that is stable at every falling edge.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case the bench wedges somewhere unforeseen.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < ND; i++) begin
            r += int'(v[4*i +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int t = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok = 1'b1;
        for (int i = 0; i < ND; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // Offer one operand (called at a falling edge); wait for acceptance and queue the expected outcome.
    task automatic applyStimulus(input logic [W-1:0] data, input logic clear, input logic hold,
                                 output int acc_cyc);
        exp_t e;
        int   waited = 0;
        int   sum;
        in_valid = 1'b1;
        in_data  = data;
        in_clear = clear;
        acc_cyc  = -1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        if (all_bcd(data)) begin
            sum       = (clear ? 0 : bcd2int(model_acc)) + bcd2int(data);
            model_ovf = (sum >= 100000);
            model_acc = int2bcd(sum % 100000);
            e.is_err  = 1'b0;
            e.cyc     = cyc + ND + 1;
        end else begin
            e.is_err  = 1'b1;
            e.cyc     = cyc + 1;
        end
        e.acc = model_acc;
        e.ovf = model_ovf;
        sb_q.push_back(e);
        @(negedge clk);
        if (!hold) begin
            in_valid = 1'b0;
            in_clear = 1'b0;
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_pending", 32'(sb_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every acc_valid or in_error pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        int   busy_run = 0;
        int   last_run = 0;
        logic busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                busy_run++;
            end else if (busy_prev) begin
                last_run = busy_run;
                busy_run = 0;
            end
            busy_prev = busy;
            if (!rst && (acc_valid || in_error)) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_event", {30'd0, acc_valid, in_error}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("event_kind", {30'd0, acc_valid, in_error}, e.is_err ? 32'd1 : 32'd2);
                    checkOutput("acc_out", 32'(acc_out), 32'(e.acc));
                    checkOutput("overflow", 32'(overflow), 32'(e.ovf));
                    checkOutput("event_cycle", 32'(cyc), 32'(e.cyc));
                    if (!e.is_err) checkOutput("busy_cycles", 32'(last_run), 32'(ND));
                end
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        int a1, a2, a3, k;

        // Reset held for two edges, then released.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_acc_out", 32'(acc_out), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_acc_valid", 32'(acc_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_error", 32'(in_error), 32'd0);

        // Clear-load then accumulate.
        applyStimulus(20'h12345, 1'b1, 1'b0, a1);
        applyStimulus(20'h54321, 1'b0, 1'b0, a2);
        drain();
        checkOutput("sum_66666", 32'(acc_out), 32'h66666);

        // Carry ripples through every digit and wraps.
        applyStimulus(20'h99999, 1'b1, 1'b0, a1);
        applyStimulus(20'h00001, 1'b0, 1'b0, a2);
        drain();
        checkOutput("wrap_acc", 32'(acc_out), 32'h00000);
        checkOutput("wrap_ovf", 32'(overflow), 32'd1);
        applyStimulus(20'h00005, 1'b0, 1'b0, a1);
        drain();
        checkOutput("after_wrap_acc", 32'(acc_out), 32'h00005);
        checkOutput("after_wrap_ovf", 32'(overflow), 32'd0);

        // Non-BCD operands are rejected without touching the sum.
        applyStimulus(20'h00042, 1'b1, 1'b0, a1);
        drain();
        applyStimulus(20'h0000A, 1'b0, 1'b0, a1);
        applyStimulus(20'hF0000, 1'b0, 1'b0, a2);
        drain();
        checkOutput("err_acc_kept", 32'(acc_out), 32'h00042);

        // in_valid held high across three operands: accepts only in IDLE/DONE.
        applyStimulus(20'h11111, 1'b1, 1'b1, a1);
        applyStimulus(20'h11111, 1'b0, 1'b1, a2);
        applyStimulus(20'h11111, 1'b0, 1'b0, a3);
        checkOutput("b2b_spacing_1", 32'(a2 - a1), 32'(ND + 1));
        checkOutput("b2b_spacing_2", 32'(a3 - a2), 32'(ND + 1));
        drain();
        checkOutput("b2b_acc", 32'(acc_out), 32'h33333);

        // Reset asserted in the third ADD cycle aborts the add.
        applyStimulus(20'h44444, 1'b1, 1'b0, a1);
        drain();
        in_valid = 1'b1;
        in_data  = 20'h55555;
        in_clear = 1'b0;
        checkOutput("midrst_ready", 32'(in_ready), 32'd1);
        k = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midrst_cycle", 32'(cyc - k), 32'd3);
        checkOutput("midrst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_acc_out", 32'(acc_out), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_busy_low", 32'(busy), 32'd0);
        checkOutput("midrst_no_valid", 32'(acc_valid), 32'd0);
        rst = 1'b0;
        model_acc = '0;
        model_ovf = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("midrst_idle_acc", 32'(acc_out), 32'd0);

        checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_serial_accumulator.md
Name: bcd_serial_accumulator

Overview:
- Digit-serial BCD accumulator controller for the decimal multiplier datapath.
- Accepts NUM_DIGITS-digit packed BCD operands over a valid/ready handshake and adds each one into a running BCD sum.
- Sequences one single-digit corrected BCD adder over all digits, LSD first, one digit per clock, with a registered decimal carry.
- Used to accumulate partial products where a full parallel adder chain is too costly.

Parameters:
- NUM_DIGITS, 5, number of BCD digits in operands and accumulator. Minimum 2.
- CNT_W, $clog2(NUM_DIGITS), width of the digit index counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  4*NUM_DIGITS  packed BCD operand; digit i is in_data[4i+3:4i].
- in_clear  input  1  sampled with the operand; when high, the accumulator is treated as zero, so the sum equals the operand.
- acc_out  output  4*NUM_DIGITS  last completed accumulator value.
- acc_valid  output  1  one-cycle pulse when acc_out is updated.
- overflow  output  1  carry out of the MSD on the last completed add.
- in_error  output  1  one-cycle pulse when an operand was rejected for a non-BCD digit.
- busy  output  1  an add is in progress.

Behaviour:
- Single clock, clk. Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: state=IDLE, acc_out=0, working registers=0, carry=0, acc_valid=0, overflow=0, in_error=0, busy=0, in_ready=1.
- States: IDLE, ADD, DONE.
- in_ready = 1 in IDLE and DONE; 0 in ADD. Accept = in_valid & in_ready.

IDLE / DONE:
- On accept with every input digit <= 9:
  - Latch the operand into the operand shift register.
  - Load the working accumulator with 0 if in_clear, else with acc_out.
  - carry <= 0, index <= 0, go to ADD.
- On accept with any input digit > 9:
  - Pulse in_error for one cycle, starting the cycle after accept.
  - acc_out and overflow are unchanged; no acc_valid.
  - Stay in or return to IDLE.
- No accept: DONE goes to IDLE; IDLE holds.

ADD (one cycle per digit):
- Digit adder inputs: working digit 0, operand digit 0, carry.
- Result digit enters at the MSD end while both shift registers rotate right by 4; carry <= decimal carry out.
- index increments each cycle.
- When index == NUM_DIGITS-1:
  - acc_out <= final working value (already realigned).
  - overflow <= final carry.
  - Go to DONE.

DONE:
- acc_valid = 1 for exactly this cycle.
- Back-to-back accept is allowed here.

Timing:
- Latency: accept at edge T0; digits are processed in cycles T0+1 .. T0+NUM_DIGITS; acc_valid is high in cycle T0+NUM_DIGITS+1.
- Throughput: one operand per NUM_DIGITS+1 cycles.
- busy = (state == ADD).

Data rules:
- acc_out changes only on completion; it is never scrambled mid-add.
- Result is modulo 10^NUM_DIGITS; overflow flags the wrap.
- in_valid while busy is ignored (not accepted); the source must hold it until in_ready.

Reset mid-add:
- The operation is aborted.
- All registers return to reset values on the next edge; no acc_valid.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4, BCD_MAX = 4'd9.
  - State enum {IDLE, ADD, DONE}.
  - Function is_bcd_word(word, ndigits).
- Sub-module bcd_digit_adder: purely combinational.
  - Inputs: a[3:0], b[3:0], cin. Outputs: s[3:0], cout.
  - Computes the binary sum; adds 6 when the sum > 9 or the binary carry is set; cout is that decision.
- Controller FSM, counter and shift registers stay in bcd_serial_accumulator.

Test Plan:
1. Reset: assert rst for 2 cycles, then release -> acc_out=0, overflow=0, acc_valid=0, in_ready=1, busy=0.
2. Clear then add:
   - Accept 0x12345 with in_clear=1, then 0x54321 with in_clear=0.
   - acc_out=0x12345, then 0x66666.
   - acc_valid exactly 6 cycles after each accept; busy high for 5 cycles; overflow=0.
3. Full carry ripple: clear with 0x99999, then add 0x00001 -> acc_out=0x00000, overflow=1. Next, add 0x00005 -> acc_out=0x00005, overflow=0.
4. Invalid digit: from acc_out=0x00042, offer 0x0000A -> in_error pulses once, acc_out stays 0x00042, no acc_valid.
   - Also offer 0xF0000 -> same response.
5. Back-to-back:
   - Hold in_valid=1 with 0x11111 (clear first) for 3 operands.
   - Accepts occur only in IDLE/DONE, spaced 6 cycles apart.
   - acc_out goes 0x11111, 0x22222, 0x33333; in_valid during ADD is never accepted.
6. Reset mid-op: assert rst on the 3rd ADD cycle of adding 0x55555 to 0x44444 -> next cycle acc_out=0, state IDLE, no acc_valid, in_ready=1.
